data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: clock edges from request acceptance to response.
REQ-004 Port clk, input, 1: single clock; all state changes on posedge clk.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port MemRead, input, 1: CPU read strobe.
REQ-007 Port MemWrite, input, 1: CPU write strobe.
REQ-008 Port dataAddress, input, 32: byte address from CPU.
REQ-009 Port dataIn, input, 32: write data from CPU.
REQ-010 Port dataOut, output, 32: read data to CPU, registered.
REQ-011 Port memReady, output, 1: one-cycle completion pulse, registered.
REQ-012 Port memFault, output, 1: error flag, valid only while memReady=1, registered.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-014 In IDLE, a posedge with MemRead=1 or MemWrite=1 SHALL accept a request: capture address, write data, and op; load the counter with LATENCY-1; go to BUSY.
REQ-015 In IDLE with both strobes low, the FSM SHALL remain in IDLE.
REQ-016 A request SHALL be marked faulted if addr[1:0]!=0, or (addr-BASE_ADDR) >= DEPTH_WORDS*4 (unsigned, 32-bit), or both strobes are high at acceptance.
REQ-017 In BUSY, each posedge SHALL decrement the counter while it is nonzero; the posedge with counter==0 SHALL execute the op and go to RESP.
REQ-018 Execute write, not faulted: mem[(addr-BASE_ADDR)>>2] <= captured data.
REQ-019 Execute read, not faulted: dataOut <= mem[(addr-BASE_ADDR)>>2].
REQ-020 Faulted execute: memory SHALL NOT be modified; dataOut <= 0 for faulted reads and faulted dual-strobe requests; dataOut SHALL be unchanged for faulted writes.
REQ-021 In RESP, memReady=1 and memFault=fault flag for exactly one cycle; the next posedge SHALL return to IDLE unconditionally.
REQ-022 Strobes SHALL be ignored in BUSY and RESP; inputs are sampled only at acceptance.
REQ-023 Latency: for a request accepted at edge T, memReady SHALL be high between edges T+LATENCY and T+LATENCY+1.
REQ-024 A strobe held high SHALL produce back-to-back transactions with period LATENCY+2 cycles.
REQ-025 dataOut SHALL hold its value until the next completed read, a faulted non-write, or reset.
REQ-026 A successful write SHALL leave dataOut unchanged.
REQ-027 Memory array contents SHALL NOT be reset and are undefined until written.

Reset
REQ-028 While reset=0, asynchronously: state=IDLE, counter=0, memReady=0, memFault=0, dataOut=0.
REQ-029 Reset asserted in BUSY or RESP SHALL abort the transaction; a pending write SHALL NOT reach memory.
REQ-030 After reset deasserts, the first posedge SHALL be eligible to accept a request.

Verification (LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=256)
REQ-031 Write then read.
- Stimulus: write 0x12345678 to 0x10, then read 0x10.
- Response: memReady high 2 edges after each acceptance; memFault=0; dataOut=0x12345678 after the read.
REQ-032 Misaligned read.
- Stimulus: read 0x13.
- Response: memReady=1 with memFault=1; dataOut=0.
REQ-033 Out-of-range write.
- Stimulus: write 0xFFFF0000 to 0x400, then read 0x0 (previously written 0x11).
- Response: first transaction has memFault=1; the read returns 0x11.
REQ-034 Dual strobe.
- Stimulus: MemRead=MemWrite=1 at 0x20 with dataIn=0x5; then a normal read of 0x20 (previously written 0x7).
- Response: first transaction has memFault=1 and dataOut=0; the normal read returns 0x7.
REQ-035 Reset during write.
- Stimulus: write 0xAAAA to 0x20 (old value 0x7); reset low for one cycle while in BUSY.
- Response: no memReady pulse; a later read of 0x20 returns 0x7; dataOut=0 immediately on reset.
REQ-036 Held strobe.
- Stimulus: MemRead held high for 12 cycles at 0x10.
- Response: memReady pulses every 4 cycles, 3 pulses total; each returns 0x12345678.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// CPU-side data memory bus: request strobes, address and write data in one direction,
// registered read data plus completion/fault flags in the other.
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dataAddress;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        memReady;
    logic        memFault;

    modport master (
        output MemRead,
        output MemWrite,
        output dataAddress,
        output dataIn,
        input  dataOut,
        input  memReady,
        input  memFault
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  dataAddress,
        input  dataIn,
        output dataOut,
        output memReady,
        output memFault
    );
endinterface

// File: rtl/data_mem_responder.sv
// Fixed-latency word-addressed data memory: accepts one request in IDLE, waits in BUSY,
// executes and then raises a one-cycle memReady (with memFault) in RESP.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD  = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [3:0]      cnt_r;
    logic [AW-1:0]   idx_r;
    logic [31:0]     wdata_r;
    logic            op_rd_r;
    logic            op_wr_r;
    logic            fault_r;
    logic [31:0]     data_out_r;
    logic            ready_r;
    logic            mem_fault_r;
    logic [31:0]     mem_r [DEPTH_WORDS];

    logic            accept_s;
    logic            exec_s;
    logic            req_fault_s;
    logic [31:0]     offset_s;

    // Request decode: acceptance, byte offset into the array and fault classification.
    always_comb begin
        accept_s    = 1'b0;
        exec_s      = 1'b0;
        offset_s    = bus.dataAddress - BASE_ADDR;
        req_fault_s = (bus.dataAddress[1:0] != 2'b00)
                    || ({1'b0, offset_s} >= MEM_BYTES)
                    || (bus.MemRead && bus.MemWrite);
        if (state_r == IDLE) begin
            accept_s = bus.MemRead || bus.MemWrite;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == BUSY) && (cnt_r == 4'd0)) begin
            exec_s = 1'b1;
        end else begin
            exec_s = 1'b0;
        end
    end

    // Next-state logic; RESP always falls back to IDLE regardless of strobes.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (cnt_r == 4'd0) begin
                    state_s = RESP;
                end else begin
                    state_s = BUSY;
                end
            end
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latency counter: loaded at acceptance, counts down while waiting in BUSY.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= 4'd0;
        end else if (accept_s) begin
            cnt_r <= CNT_LOAD;
        end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Request capture; inputs are only looked at on the accepting edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_r   <= {AW{1'b0}};
            wdata_r <= 32'h0000_0000;
            op_rd_r <= 1'b0;
            op_wr_r <= 1'b0;
            fault_r <= 1'b0;
        end else if (accept_s) begin
            idx_r   <= offset_s[AW+1:2];
            wdata_r <= bus.dataIn;
            op_rd_r <= bus.MemRead;
            op_wr_r <= bus.MemWrite;
            fault_r <= req_fault_s;
        end else begin
            idx_r   <= idx_r;
            wdata_r <= wdata_r;
            op_rd_r <= op_rd_r;
            op_wr_r <= op_wr_r;
            fault_r <= fault_r;
        end
    end

    // Storage array, deliberately unreset; an aborted transaction never reaches exec_s.
    always_ff @(posedge clk) begin
        if (exec_s && op_wr_r && !op_rd_r && !fault_r) begin
            mem_r[idx_r] <= wdata_r;
        end
    end

    // Registered response; dataOut moves only on reads and faulted dual-strobe requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_r     <= 1'b0;
            mem_fault_r <= 1'b0;
            data_out_r  <= 32'h0000_0000;
        end else begin
            ready_r     <= exec_s;
            mem_fault_r <= exec_s && fault_r;
            if (exec_s && op_rd_r) begin
                if (fault_r) begin
                    data_out_r <= 32'h0000_0000;
                end else begin
                    data_out_r <= mem_r[idx_r];
                end
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.dataOut  = data_out_r;
    assign bus.memReady = ready_r;
    assign bus.memFault = mem_fault_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=256).
module tb_data_mem_responder;

    localparam int LAT = 2;

    typedef struct {
        int          cyc;
        logic        fault;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   n_pulse;
    int   n_exp_pulse;
    exp_t sb_q[$];

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS(256),
        .BASE_ADDR  (32'h0000_0000),
        .LATENCY    (LAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every memReady pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && bus.memReady === 1'b1) begin
            n_pulse++;
            if (sb_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("ready_cycle", 32'(cyc), 32'(e.cyc));
                check("mem_fault", {31'd0, bus.memFault}, {31'd0, e.fault});
                check("data_out", bus.dataOut, e.data);
            end
        end
    end

    task automatic push_exp(input int c, input logic f, input logic [31:0] d);
        exp_t e;
        e.cyc   = c;
        e.fault = f;
        e.data  = d;
        sb_q.push_back(e);
        n_exp_pulse++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb_q.size() != 0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        if (sb_q.size() != 0) begin
            check("timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic efault, input logic [31:0] edata);
        @(negedge clk);
        bus.MemRead     = rd;
        bus.MemWrite    = wr;
        bus.dataAddress = addr;
        bus.dataIn      = data;
        push_exp(cyc + 1 + LAT, efault, edata);
        @(negedge clk);
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        drain();
    endtask

    initial begin
        int base;
        cyc             = 0;
        n_vec           = 0;
        n_err           = 0;
        n_pulse         = 0;
        n_exp_pulse     = 0;
        reset           = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.dataAddress = 32'h0;
        bus.dataIn      = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, bus.memReady}, 32'd0);
        check("rst_fault", {31'd0, bus.memFault}, 32'd0);
        check("rst_data", bus.dataOut, 32'h0);
        reset = 1'b1;

        issue(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0011, 1'b0, 32'h0);
        issue(1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'h1234_5678);
        issue(1'b0, 1'b1, 32'h0000_0022, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
        issue(1'b1, 1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'h0);
        issue(1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_0000, 1'b1, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0000_0011);
        issue(1'b1, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0);
        issue(1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 1'b0, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_03FC, 32'h0,         1'b0, 32'hCAFE_F00D);
        issue(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0007, 1'b0, 32'hCAFE_F00D);
        issue(1'b1, 1'b1, 32'h0000_0020, 32'h0000_0005, 1'b1, 32'h0);
        issue(1'b1, 1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'h0000_0007);

        // Reset in BUSY aborts the pending write and clears dataOut at once.
        @(negedge clk);
        bus.MemWrite    = 1'b1;
        bus.dataAddress = 32'h0000_0020;
        bus.dataIn      = 32'h0000_AAAA;
        @(negedge clk);
        bus.MemWrite = 1'b0;
        reset        = 1'b0;
        #1;
        check("abort_data", bus.dataOut, 32'h0);
        check("abort_ready", {31'd0, bus.memReady}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        issue(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h0000_0007);

        // Held read strobe: one transaction every LAT+2 cycles.
        @(negedge clk);
        bus.MemRead     = 1'b1;
        bus.dataAddress = 32'h0000_0010;
        base            = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push_exp(base + k * (LAT + 2) + LAT, 1'b0, 32'h1234_5678);
        end
        repeat (12) @(negedge clk);
        bus.MemRead = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        check("pulse_count", 32'(n_pulse), 32'(n_exp_pulse));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
